// File: rtl/coso_pkg.sv
// coso_pkg -- shared types and constants for the COSO beat sequencer.
//   state_t   : sequencer states (IDLE, ARM, COUNT)
//   CNT_W_DEF : default width of the beat-period counter
//   CNT_MAX   : saturation value of a CNT_W_DEF-wide counter (2^CNT_W_DEF - 1)
package coso_pkg;

  localparam int unsigned CNT_W_DEF = 16;
  localparam logic [CNT_W_DEF-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2
  } state_t;

endpackage

// File: rtl/coso_out_reg.sv
// coso_out_reg -- single-entry valid/ready result register.
// Ports:
//   clk, clr     : clock, asynchronous active-high reset
//   load, data   : one-cycle strobe offering a new period measurement
//   rdy          : consumer ready
//   bitOut       : data[0] of the held result
//   cntOut       : held result
//   bitValid     : result held and not yet consumed
//   drop         : registered pulse, offered result was discarded
//
// Handshake: a result is consumed on every rising edge where bitValid=1 and
// rdy=1. A load is accepted when the register is empty or is being consumed
// in the same cycle; otherwise the offered result is dropped and the held
// result is left untouched.
module coso_out_reg #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] data,
  input  logic         rdy,
  output logic         bitOut,
  output logic [W-1:0] cntOut,
  output logic         bitValid,
  output logic         drop
);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      bitOut   <= 1'b0;
      cntOut   <= '0;
      bitValid <= 1'b0;
      drop     <= 1'b0;
    end else begin
      drop <= 1'b0;
      if (load) begin
        if (!bitValid || rdy) begin
          cntOut   <= data;
          bitOut   <= data[0];
          bitValid <= 1'b1;
        end else begin
          drop <= 1'b1;
        end
      end else if (bitValid && rdy) begin
        bitValid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/coso_beat_ctrl.sv
// coso_beat_ctrl -- sequencer for one COSO entropy source.
// Controls the beat-divider TFF and measures the beat period in clk cycles;
// each completed period is offered to a valid/ready output register.
// Ports:
//   clk, clr        : clock, asynchronous active-high reset
//   en              : run request (level)
//   beat            : sampled beat, synchronous to clk
//   rdy             : consumer ready for bitOut/cntOut
//   tffClr, tffEn   : registered controls for the beat-divider TFF
//   bitOut, cntOut  : period LSB and full period of the held result
//   bitValid        : unconsumed result held
//   ovf             : pulse, period counter saturated, measurement discarded
//   drop            : pulse, result discarded because output was occupied
//   dbgState        : current sequencer state, for observation only
module coso_beat_ctrl
  import coso_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             beat,
  input  logic             rdy,
  output logic             tffClr,
  output logic             tffEn,
  output logic             bitOut,
  output logic [CNT_W-1:0] cntOut,
  output logic             bitValid,
  output logic             ovf,
  output logic             drop,
  output state_t           dbgState
);

  // Saturation value for this instance's counter width (CNT_MAX covers the
  // default width only).
  localparam logic [CNT_W-1:0] CNT_SAT = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic             beatQ;
  logic             rise;
  logic [CNT_W-1:0] cnt;
  logic             loadReq;

  assign rise     = beat & ~beatQ;
  assign dbgState = state;

  // A rise in COUNT closes the running period; en=0 discards it.
  assign loadReq = en && (state == COUNT) && rise;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state  <= IDLE;
      beatQ  <= 1'b0;
      cnt    <= '0;
      tffClr <= 1'b1;
      tffEn  <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      beatQ  <= beat;
      ovf    <= 1'b0;
      // TFF controls follow the state register with one cycle of lag.
      tffClr <= (state == IDLE);
      tffEn  <= (state != IDLE);
      if (!en) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            state <= ARM;
            cnt   <= '0;
          end
          ARM: begin
            if (rise) begin
              state <= COUNT;
              cnt   <= CNT_ONE;
            end
          end
          COUNT: begin
            // The closing rise also opens the next period, so a rise on the
            // saturated count still delivers and restarts at 1.
            if (rise) begin
              cnt <= CNT_ONE;
            end else if (cnt == CNT_SAT) begin
              ovf   <= 1'b1;
              state <= ARM;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  coso_out_reg #(
    .W(CNT_W)
  ) u_out_reg (
    .clk      (clk),
    .clr      (clr),
    .load     (loadReq),
    .data     (cnt),
    .rdy      (rdy),
    .bitOut   (bitOut),
    .cntOut   (cntOut),
    .bitValid (bitValid),
    .drop     (drop)
  );

endmodule

// File: tb/tb_coso_beat_ctrl.sv
module tb_coso_beat_ctrl;
  import coso_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic clr = 1'b1;
  logic en = 1'b0;
  logic beat = 1'b0;
  logic rdy = 1'b0;

  always #5 clk = ~clk;

  // 16-bit instance: main checks
  logic        tff_clr, tff_en, bit_out, bit_valid, ovf, drop;
  logic [15:0] cnt_out;
  state_t      dbg_state;

  // 4-bit instance: overflow checks (shares all inputs)
  logic        tff_clr4, tff_en4, bit_out4, bit_valid4, ovf4, drop4;
  logic [3:0]  cnt_out4;
  state_t      dbg_state4;

  coso_beat_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .clr(clr), .en(en), .beat(beat), .rdy(rdy),
    .tffClr(tff_clr), .tffEn(tff_en), .bitOut(bit_out), .cntOut(cnt_out),
    .bitValid(bit_valid), .ovf(ovf), .drop(drop), .dbgState(dbg_state)
  );

  coso_beat_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .clr(clr), .en(en), .beat(beat), .rdy(rdy),
    .tffClr(tff_clr4), .tffEn(tff_en4), .bitOut(bit_out4), .cntOut(cnt_out4),
    .bitValid(bit_valid4), .ovf(ovf4), .drop(drop4), .dbgState(dbg_state4)
  );

  int vecs = 0;
  int errs = 0;

  // ---------------- driver tasks ----------------
  // Advance one edge; inputs are changed and outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // beat high for one edge: that edge samples a rise.
  task automatic beat_pulse();
    beat = 1'b1;
    tick();
    beat = 1'b0;
  endtask

  // Rise P edges after the previous rise.
  task automatic run_period(input int p);
    wait_ticks(p - 1);
    beat_pulse();
  endtask

  // Return both instances to IDLE with an empty output register.
  task automatic restart();
    en   = 1'b0;
    rdy  = 1'b1;
    beat = 1'b0;
    wait_ticks(3);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    wait_ticks(2);
    vecs++; if (tff_clr !== 1'b1) begin errs++; $display("FAIL rst_tffclr: got %0d want 1", tff_clr); end
    vecs++; if (tff_en !== 1'b0) begin errs++; $display("FAIL rst_tffen: got %0d want 0", tff_en); end
    vecs++; if (bit_valid !== 1'b0 || cnt_out !== 16'd0 || bit_out !== 1'b0)
      begin errs++; $display("FAIL rst_out: valid %0d cnt %0d bit %0d want 0 0 0", bit_valid, cnt_out, bit_out); end
    clr = 1'b0;
    en  = 1'b1;
    tick();
    beat_pulse();
    run_period(5);
    wait_ticks(2);
    vecs++; if (bit_valid !== 1'b1 || dbg_state !== COUNT)
      begin errs++; $display("FAIL pre_clr: valid %0d state %0d want 1 %0d", bit_valid, dbg_state, COUNT); end
    // asynchronous clear away from any clock edge
    clr = 1'b1;
    #1;
    vecs++; if (tff_clr !== 1'b1 || tff_en !== 1'b0)
      begin errs++; $display("FAIL async_tff: clr %0d en %0d want 1 0", tff_clr, tff_en); end
    vecs++; if (bit_valid !== 1'b0 || cnt_out !== 16'd0 || bit_out !== 1'b0 || ovf !== 1'b0 || drop !== 1'b0)
      begin errs++; $display("FAIL async_out: valid %0d cnt %0d bit %0d ovf %0d drop %0d want all 0", bit_valid, cnt_out, bit_out, ovf, drop); end
    vecs++; if (dbg_state !== IDLE) begin errs++; $display("FAIL async_state: got %0d want %0d", dbg_state, IDLE); end
    tick();
    clr = 1'b0;
    restart();
  endtask

  task automatic test_periodic(input int p, input int n);
    logic [15:0] exp_q[$];
    logic [15:0] exp_v;
    restart();
    en  = 1'b1;
    rdy = 1'b1;
    tick();
    beat_pulse();
    vecs++; if (bit_valid !== 1'b0) begin errs++; $display("FAIL arm_novalid_p%0d: got %0d want 0", p, bit_valid); end
    vecs++; if (tff_en !== 1'b1 || tff_clr !== 1'b0)
      begin errs++; $display("FAIL arm_tff_p%0d: en %0d clr %0d want 1 0", p, tff_en, tff_clr); end
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(16'(p));
      tick();
      vecs++; if (bit_valid !== 1'b0) begin errs++; $display("FAIL pulse_once_p%0d: valid %0d want 0", p, bit_valid); end
      wait_ticks(p - 2);
      beat_pulse();
      exp_v = exp_q.pop_front();
      vecs++; if (bit_valid !== 1'b1 || cnt_out !== exp_v || bit_out !== exp_v[0] || drop !== 1'b0)
        begin errs++; $display("FAIL period_p%0d: valid %0d cnt %0d bit %0d drop %0d want 1 %0d %0d 0", p, bit_valid, cnt_out, bit_out, drop, exp_v, exp_v[0]); end
    end
  endtask

  task automatic test_back_pressure();
    restart();
    en  = 1'b1;
    rdy = 1'b0;
    tick();
    beat_pulse();
    run_period(5);
    vecs++; if (bit_valid !== 1'b1 || cnt_out !== 16'd5)
      begin errs++; $display("FAIL bp_first: valid %0d cnt %0d want 1 5", bit_valid, cnt_out); end
    // later periods differ from 5 so an overwrite would be visible
    for (int k = 0; k < 2; k++) begin
      tick();
      vecs++; if (drop !== 1'b0) begin errs++; $display("FAIL bp_drop_idle%0d: got %0d want 0", k, drop); end
      wait_ticks((k == 0 ? 6 : 4) - 2);
      beat_pulse();
      vecs++; if (drop !== 1'b1 || cnt_out !== 16'd5 || bit_out !== 1'b1 || bit_valid !== 1'b1)
        begin errs++; $display("FAIL bp_drop%0d: drop %0d cnt %0d bit %0d valid %0d want 1 5 1 1", k, drop, cnt_out, bit_out, bit_valid); end
    end
    rdy = 1'b1;
    tick();
    vecs++; if (bit_valid !== 1'b0 || cnt_out !== 16'd5 || drop !== 1'b0)
      begin errs++; $display("FAIL bp_xfer: valid %0d cnt %0d drop %0d want 0 5 0", bit_valid, cnt_out, drop); end
  endtask

  task automatic test_overflow();
    restart();
    en = 1'b1;
    tick();
    beat_pulse();
    wait_ticks(14);
    vecs++; if (ovf4 !== 1'b0 || dbg_state4 !== COUNT)
      begin errs++; $display("FAIL ovf_early: ovf %0d state %0d want 0 %0d", ovf4, dbg_state4, COUNT); end
    tick();
    vecs++; if (ovf4 !== 1'b1 || dbg_state4 !== ARM)
      begin errs++; $display("FAIL ovf_pulse: ovf %0d state %0d want 1 %0d", ovf4, dbg_state4, ARM); end
    tick();
    vecs++; if (ovf4 !== 1'b0 || bit_valid4 !== 1'b0)
      begin errs++; $display("FAIL ovf_after: ovf %0d valid %0d want 0 0", ovf4, bit_valid4); end
    // rise exactly on the saturated count delivers 15
    beat_pulse();
    run_period(15);
    vecs++; if (bit_valid4 !== 1'b1 || cnt_out4 !== 4'd15 || bit_out4 !== 1'b1 || ovf4 !== 1'b0)
      begin errs++; $display("FAIL sat_rise: valid %0d cnt %0d bit %0d ovf %0d want 1 15 1 0", bit_valid4, cnt_out4, bit_out4, ovf4); end
    tick();
    vecs++; if (ovf4 !== 1'b0 || dbg_state4 !== COUNT)
      begin errs++; $display("FAIL sat_rise_next: ovf %0d state %0d want 0 %0d", ovf4, dbg_state4, COUNT); end
  endtask

  task automatic test_disable();
    restart();
    en = 1'b1;
    tick();
    beat_pulse();
    wait_ticks(2);
    en = 1'b0;
    tick();
    vecs++; if (dbg_state !== IDLE) begin errs++; $display("FAIL dis_state: got %0d want %0d", dbg_state, IDLE); end
    tick();
    vecs++; if (tff_clr !== 1'b1 || tff_en !== 1'b0 || bit_valid !== 1'b0)
      begin errs++; $display("FAIL dis_tff: clr %0d en %0d valid %0d want 1 0 0", tff_clr, tff_en, bit_valid); end
    beat_pulse();
    vecs++; if (bit_valid !== 1'b0) begin errs++; $display("FAIL dis_beat: valid %0d want 0", bit_valid); end
    en = 1'b1;
    tick();
    wait_ticks(3);
    beat_pulse();
    vecs++; if (bit_valid !== 1'b0 || dbg_state !== COUNT)
      begin errs++; $display("FAIL rearm: valid %0d state %0d want 0 %0d", bit_valid, dbg_state, COUNT); end
    run_period(6);
    vecs++; if (bit_valid !== 1'b1 || cnt_out !== 16'd6 || bit_out !== 1'b0)
      begin errs++; $display("FAIL rearm_period: valid %0d cnt %0d bit %0d want 1 6 0", bit_valid, cnt_out, bit_out); end
  endtask

  task automatic test_load_and_consume();
    restart();
    en  = 1'b1;
    rdy = 1'b0;
    tick();
    beat_pulse();
    run_period(4);
    vecs++; if (bit_valid !== 1'b1 || cnt_out !== 16'd4)
      begin errs++; $display("FAIL lc_first: valid %0d cnt %0d want 1 4", bit_valid, cnt_out); end
    wait_ticks(8);
    rdy = 1'b1;
    beat_pulse();
    vecs++; if (bit_valid !== 1'b1 || cnt_out !== 16'd9 || bit_out !== 1'b1 || drop !== 1'b0)
      begin errs++; $display("FAIL lc_swap: valid %0d cnt %0d bit %0d drop %0d want 1 9 1 0", bit_valid, cnt_out, bit_out, drop); end
    tick();
    vecs++; if (bit_valid !== 1'b0 || drop !== 1'b0)
      begin errs++; $display("FAIL lc_drain: valid %0d drop %0d want 0 0", bit_valid, drop); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_periodic(7, 4);
    test_periodic(10, 3);
    test_back_pressure();
    test_overflow();
    test_disable();
    test_load_and_consume();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
